idct_whole: RTL and testbench

- Streaming 2-D 4x4 inverse integer transform using the H.264-style core butterfly; row pass first, then column pass.
- Accepts one coefficient row (4 signed samples) per clock and emits one reconstructed column (4 signed samples) per clock.
- Full throughput: a new block can start every 4 cycles.
- Sits between the dequantiser and the residual/reconstruction adder in the decode datapath.

---
 rtl/idct_pkg.sv | 11 +
 rtl/idct_whole_idct4_1d.sv | 34 +++
 rtl/idct_whole.sv | 116 +++++++++++
 tb/tb_idct_whole.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared widths and constants for the 4x4 inverse integer transform.
package idct_pkg;

    // I/O sample width (signed two's complement).
    localparam int DW = 25;
    // Row-result and transpose-buffer width (signed).
    localparam int IW = 28;
    // Arithmetic right-shift applied to the odd inputs of the butterfly.
    localparam int BFLY_SHIFT = 1;

endpackage : idct_pkg

// File: rtl/idct_whole_idct4_1d.sv
// Combinational 4-point H.264-style inverse butterfly, width-parameterised.
module idct4_1d
    import idct_pkg::*;
#(
    parameter int W = IW
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    input  logic signed [W-1:0] i_c,
    input  logic signed [W-1:0] i_d,
    output logic signed [W-1:0] o_y0,
    output logic signed [W-1:0] o_y1,
    output logic signed [W-1:0] o_y2,
    output logic signed [W-1:0] o_y3
);

    logic signed [W-1:0] w_e;
    logic signed [W-1:0] w_f;
    logic signed [W-1:0] w_g;
    logic signed [W-1:0] w_h;

    // Even/odd split; >>> on signed operands floors toward minus infinity.
    assign w_e = i_a + i_c;
    assign w_f = i_a - i_c;
    assign w_g = (i_b >>> BFLY_SHIFT) - i_d;
    assign w_h = i_b + (i_d >>> BFLY_SHIFT);

    // Recombination stage.
    assign o_y0 = w_e + w_h;
    assign o_y1 = w_f + w_g;
    assign o_y2 = w_f - w_g;
    assign o_y3 = w_e - w_h;

endmodule : idct4_1d

// File: rtl/idct_whole.sv
// Streaming 2-D 4x4 inverse transform: one coefficient row in per clock,
// one reconstructed column out per clock, ping-pong transpose buffer between
// the row and column passes so consecutive blocks stream without bubbles.
module idct_whole
    import idct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] d_in_1_ori,
    input  logic signed [DW-1:0] d_in_2_ori,
    input  logic signed [DW-1:0] d_in_3_ori,
    input  logic signed [DW-1:0] d_in_4_ori,
    output logic signed [DW-1:0] d_out_5_fin,
    output logic signed [DW-1:0] d_out_6_fin,
    output logic signed [DW-1:0] d_out_7_fin,
    output logic signed [DW-1:0] d_out_8_fin
);

    localparam int CW = IW + 2;

    // Row counter: row being written and, in parallel, column being read.
    logic [1:0]          r_cnt;
    // Bank currently receiving row results; the other bank feeds the column pass.
    logic                r_wbank;
    // Transpose buffer indexed [bank][row][column].
    logic signed [IW-1:0] r_buf [2][4][4];
    logic signed [DW-1:0] r_out5;
    logic signed [DW-1:0] r_out6;
    logic signed [DW-1:0] r_out7;
    logic signed [DW-1:0] r_out8;

    logic                 w_rbank;
    logic signed [IW-1:0] w_ra, w_rb, w_rc, w_rd;
    logic signed [IW-1:0] w_ry0, w_ry1, w_ry2, w_ry3;
    logic signed [CW-1:0] w_ca, w_cb, w_cc, w_cd;
    logic signed [CW-1:0] w_cy0, w_cy1, w_cy2, w_cy3;

    // Row pass operands: sign-extend the DW-bit coefficients to IW bits.
    assign w_ra = {{(IW-DW){d_in_1_ori[DW-1]}}, d_in_1_ori};
    assign w_rb = {{(IW-DW){d_in_2_ori[DW-1]}}, d_in_2_ori};
    assign w_rc = {{(IW-DW){d_in_3_ori[DW-1]}}, d_in_3_ori};
    assign w_rd = {{(IW-DW){d_in_4_ori[DW-1]}}, d_in_4_ori};

    idct4_1d #(.W(IW)) u_row (
        .i_a  (w_ra),
        .i_b  (w_rb),
        .i_c  (w_rc),
        .i_d  (w_rd),
        .o_y0 (w_ry0),
        .o_y1 (w_ry1),
        .o_y2 (w_ry2),
        .o_y3 (w_ry3)
    );

    // Column pass operands: column r_cnt of the read bank, rows 0..3 as a..d.
    assign w_rbank = ~r_wbank;
    assign w_ca = {{2{r_buf[w_rbank][0][r_cnt][IW-1]}}, r_buf[w_rbank][0][r_cnt]};
    assign w_cb = {{2{r_buf[w_rbank][1][r_cnt][IW-1]}}, r_buf[w_rbank][1][r_cnt]};
    assign w_cc = {{2{r_buf[w_rbank][2][r_cnt][IW-1]}}, r_buf[w_rbank][2][r_cnt]};
    assign w_cd = {{2{r_buf[w_rbank][3][r_cnt][IW-1]}}, r_buf[w_rbank][3][r_cnt]};

    idct4_1d #(.W(CW)) u_col (
        .i_a  (w_ca),
        .i_b  (w_cb),
        .i_c  (w_cc),
        .i_d  (w_cd),
        .o_y0 (w_cy0),
        .o_y1 (w_cy1),
        .o_y2 (w_cy2),
        .o_y3 (w_cy3)
    );

    // Counter, bank swap, row write-back and registered column outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 2'd0;
            r_wbank <= 1'b0;
            // NOTE: the buffer is reset on purpose: the column pass reads the
            // idle bank before the first block lands and must present zeros,
            // and a reset mid-block must not leak the partial block.
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        r_buf[b][r][c] <= '0;
                    end
                end
            end
            r_out5 <= '0;
            r_out6 <= '0;
            r_out7 <= '0;
            r_out8 <= '0;
        end else begin
            // NOTE: non-blocking assignments make the column read below see the
            // pre-edge buffer and counter, so write and read never race.
            r_buf[r_wbank][r_cnt][0] <= w_ry0;
            r_buf[r_wbank][r_cnt][1] <= w_ry1;
            r_buf[r_wbank][r_cnt][2] <= w_ry2;
            r_buf[r_wbank][r_cnt][3] <= w_ry3;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
                r_wbank <= ~r_wbank;
            end
            // Outputs keep the low DW bits: wrap, no saturation or rounding.
            r_out5 <= w_cy0[DW-1:0];
            r_out6 <= w_cy1[DW-1:0];
            r_out7 <= w_cy2[DW-1:0];
            r_out8 <= w_cy3[DW-1:0];
        end
    end

    assign d_out_5_fin = r_out5;
    assign d_out_6_fin = r_out6;
    assign d_out_7_fin = r_out7;
    assign d_out_8_fin = r_out8;

endmodule : idct_whole

// File: tb/tb_idct_whole.sv
// Directed bench for idct_whole: reset, single/back-to-back blocks, column
// butterfly, DC block and mid-block reset, with hand-computed expectations.
module tb_idct_whole;
    import idct_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] d_in_1_ori;
    logic signed [DW-1:0] d_in_2_ori;
    logic signed [DW-1:0] d_in_3_ori;
    logic signed [DW-1:0] d_in_4_ori;
    logic signed [DW-1:0] d_out_5_fin;
    logic signed [DW-1:0] d_out_6_fin;
    logic signed [DW-1:0] d_out_7_fin;
    logic signed [DW-1:0] d_out_8_fin;

    int checks   = 0;
    int failures = 0;

    idct_whole dut (
        .clk         (clk),
        .reset       (reset),
        .d_in_1_ori  (d_in_1_ori),
        .d_in_2_ori  (d_in_2_ori),
        .d_in_3_ori  (d_in_3_ori),
        .d_in_4_ori  (d_in_4_ori),
        .d_out_5_fin (d_out_5_fin),
        .d_out_6_fin (d_out_6_fin),
        .d_out_7_fin (d_out_7_fin),
        .d_out_8_fin (d_out_8_fin)
    );

    always #5 clk = ~clk;

    // Drive one row plus reset, take one rising edge, settle 1 time unit.
    task automatic step(input int a, input int b, input int c, input int d, input logic rst);
        reset      = rst;
        d_in_1_ori = DW'(a);
        d_in_2_ori = DW'(b);
        d_in_3_ori = DW'(c);
        d_in_4_ori = DW'(d);
        @(posedge clk);
        #1;
    endtask

    // Reset held two cycles, then a zero block: outputs stay 0 throughout.
    task automatic test_reset;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, (i < 2) ? 1'b1 : 1'b0);
            checks++;
            if (d_out_5_fin !== 0 || d_out_6_fin !== 0 || d_out_7_fin !== 0 || d_out_8_fin !== 0) begin
                failures++;
                $display("FAIL reset_zero[%0d]: got %0d %0d %0d %0d expected 0 0 0 0", i,
                         d_out_5_fin, d_out_6_fin, d_out_7_fin, d_out_8_fin);
            end
        end
    endtask

    // Re-align edge numbering with a reset pulse, then feed the single-row
    // block at edges 1..4; outputs still show the cleared/zero bank.
    task automatic test_single_row;
        int rows [4][4];
        rows = '{'{1440, -720, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        step(0, 0, 0, 0, 1'b1);
        for (int j = 0; j < 4; j++) begin
            step(rows[j][0], rows[j][1], rows[j][2], rows[j][3], 1'b0);
            checks++;
            if (d_out_5_fin !== 0 || d_out_6_fin !== 0 || d_out_7_fin !== 0 || d_out_8_fin !== 0) begin
                failures++;
                $display("FAIL single_row_fill[%0d]: got %0d %0d %0d %0d expected 0 0 0 0", j,
                         d_out_5_fin, d_out_6_fin, d_out_7_fin, d_out_8_fin);
            end
        end
    endtask

    // Second block fed with no bubble (edges 5..8) while the single-row
    // block's columns emerge: every output of column j equals row-0 result j.
    task automatic test_back_to_back;
        int rows [4][4];
        int exp_col [4];
        rows    = '{'{-720, 1440, -720, -720}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        exp_col = '{720, 1080, 1800, 2160};
        for (int j = 0; j < 4; j++) begin
            step(rows[j][0], rows[j][1], rows[j][2], rows[j][3], 1'b0);
            checks++;
            if (d_out_5_fin !== exp_col[j] || d_out_6_fin !== exp_col[j] ||
                d_out_7_fin !== exp_col[j] || d_out_8_fin !== exp_col[j]) begin
                failures++;
                $display("FAIL single_row_col[%0d]: got %0d %0d %0d %0d expected all %0d", j,
                         d_out_5_fin, d_out_6_fin, d_out_7_fin, d_out_8_fin, exp_col[j]);
            end
        end
    endtask

    // Column-butterfly block fed at edges 9..12 while the back-to-back block drains.
    task automatic test_column_butterfly;
        int rows [4][4];
        int exp_col [4];
        rows    = '{'{0, 0, 0, 0}, '{8, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        exp_col = '{-360, 1440, -1440, -2520};
        for (int j = 0; j < 4; j++) begin
            step(rows[j][0], rows[j][1], rows[j][2], rows[j][3], 1'b0);
            checks++;
            if (d_out_5_fin !== exp_col[j] || d_out_6_fin !== exp_col[j] ||
                d_out_7_fin !== exp_col[j] || d_out_8_fin !== exp_col[j]) begin
                failures++;
                $display("FAIL back_to_back_col[%0d]: got %0d %0d %0d %0d expected all %0d", j,
                         d_out_5_fin, d_out_6_fin, d_out_7_fin, d_out_8_fin, exp_col[j]);
            end
        end
    endtask

    // DC block fed while the column-butterfly block drains as (8,4,-4,-8),
    // then a zero block while the DC block drains as all 64.
    task automatic test_dc;
        int dc_rows [4][4];
        dc_rows = '{'{64, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        for (int j = 0; j < 4; j++) begin
            step(dc_rows[j][0], dc_rows[j][1], dc_rows[j][2], dc_rows[j][3], 1'b0);
            checks++;
            if (d_out_5_fin !== 8 || d_out_6_fin !== 4 || d_out_7_fin !== -4 || d_out_8_fin !== -8) begin
                failures++;
                $display("FAIL column_butterfly[%0d]: got %0d %0d %0d %0d expected 8 4 -4 -8", j,
                         d_out_5_fin, d_out_6_fin, d_out_7_fin, d_out_8_fin);
            end
        end
        for (int j = 0; j < 4; j++) begin
            step(0, 0, 0, 0, 1'b0);
            checks++;
            if (d_out_5_fin !== 64 || d_out_6_fin !== 64 || d_out_7_fin !== 64 || d_out_8_fin !== 64) begin
                failures++;
                $display("FAIL dc_block[%0d]: got %0d %0d %0d %0d expected 64 64 64 64", j,
                         d_out_5_fin, d_out_6_fin, d_out_7_fin, d_out_8_fin);
            end
        end
    endtask

    // Rows 0..2 of a non-zero block, reset on the row-3 edge, then zero
    // blocks: the partial block must never reach the outputs.
    task automatic test_mid_reset;
        int rows [4][4];
        rows = '{'{100, 50, -30, 7}, '{-200, 17, 33, -5}, '{400, -3, 9, 120}, '{77, 66, 55, 44}};
        for (int j = 0; j < 4; j++) begin
            step(rows[j][0], rows[j][1], rows[j][2], rows[j][3], (j == 3) ? 1'b1 : 1'b0);
            checks++;
            if (d_out_5_fin !== 0 || d_out_6_fin !== 0 || d_out_7_fin !== 0 || d_out_8_fin !== 0) begin
                failures++;
                $display("FAIL mid_reset_edge[%0d]: got %0d %0d %0d %0d expected 0 0 0 0", j,
                         d_out_5_fin, d_out_6_fin, d_out_7_fin, d_out_8_fin);
            end
        end
        for (int j = 0; j < 8; j++) begin
            step(0, 0, 0, 0, 1'b0);
            checks++;
            if (d_out_5_fin !== 0 || d_out_6_fin !== 0 || d_out_7_fin !== 0 || d_out_8_fin !== 0) begin
                failures++;
                $display("FAIL mid_reset_after[%0d]: got %0d %0d %0d %0d expected 0 0 0 0", j,
                         d_out_5_fin, d_out_6_fin, d_out_7_fin, d_out_8_fin);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        d_in_1_ori = '0;
        d_in_2_ori = '0;
        d_in_3_ori = '0;
        d_in_4_ori = '0;
        @(negedge clk);
        test_reset();
        test_single_row();
        test_back_to_back();
        test_column_butterfly();
        test_dc();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_idct_whole
